// File: rtl/pmod_switch_reader.sv
// PMOD switch front end: two-flop synchroniser, per-bit debounce, and a
// single-slot change-event buffer that merges further changes until the consumer accepts it.
module pmod_switch_reader #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 120000,
  localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_n_i,
  output logic [WIDTH-1:0] sw_state_o,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [WIDTH-1:0] evt_state_o,
  output logic [WIDTH-1:0] evt_changed_o,
  output logic             evt_overflow_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE, PENDING} state_t;

  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;
  logic [WIDTH-1:0] stable_n_reg;
  logic [WIDTH-1:0] stable_n_next;
  logic [WIDTH-1:0] chg;
  logic [WIDTH-1:0] new_state;
  state_t           state_reg;

  // Each pin debounces on its own counter; a bounce back to the stable level clears it.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic [CNT_W-1:0] cnt_reg;
    logic             differs;

    assign differs           = sync2_reg[gi] ^ stable_n_reg[gi];
    assign stable_n_next[gi] = (differs && (cnt_reg == CNT_MAX)) ? sync2_reg[gi]
                                                                 : stable_n_reg[gi];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg <= '0;
      end else if (differs && (cnt_reg != CNT_MAX)) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign chg       = stable_n_next ^ stable_n_reg;
  assign new_state = ~stable_n_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg    <= '1;
      sync2_reg    <= '1;
      stable_n_reg <= '1;
      sw_state_o   <= '0;
    end else begin
      sync1_reg    <= sw_n_i;
      sync2_reg    <= sync1_reg;
      stable_n_reg <= stable_n_next;
      sw_state_o   <= new_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      evt_valid_o    <= 1'b0;
      evt_state_o    <= '0;
      evt_changed_o  <= '0;
      evt_overflow_o <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|chg) begin
            state_reg      <= PENDING;
            evt_valid_o    <= 1'b1;
            evt_state_o    <= new_state;
            evt_changed_o  <= chg;
            evt_overflow_o <= 1'b0;
          end
        end
        PENDING: begin
          if (evt_ready_i) begin
            if (|chg) begin
              // Accepted and refilled on the same edge: the new change starts a fresh event.
              evt_state_o    <= new_state;
              evt_changed_o  <= chg;
              evt_overflow_o <= 1'b0;
            end else begin
              state_reg   <= IDLE;
              evt_valid_o <= 1'b0;
            end
          end else if (|chg) begin
            evt_state_o    <= new_state;
            evt_changed_o  <= evt_changed_o | chg;
            evt_overflow_o <= 1'b1;
          end
        end
        default: begin
          state_reg   <= IDLE;
          evt_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pmod_switch_reader.sv
// Bench for pmod_switch_reader with a short debounce; accepted events are checked
// against a queue of expected payloads, level behaviour against hand-derived values.
module tb_pmod_switch_reader;

  logic       clk;
  logic       rst_n;
  logic [7:0] sw_n_i;
  logic [7:0] sw_state_o;
  logic       evt_valid_o;
  logic       evt_ready_i;
  logic [7:0] evt_state_o;
  logic [7:0] evt_changed_o;
  logic       evt_overflow_o;

  typedef struct {
    logic [7:0] sw_n;
    logic [7:0] exp_state;
    logic [7:0] exp_changed;
  } vec_t;

  typedef struct {
    logic [7:0] st;
    logic [7:0] chg;
    logic       ovf;
  } evt_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  evt_t exp_q[$];
  vec_t vecs[6];

  pmod_switch_reader #(
    .WIDTH          (8),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sw_n_i        (sw_n_i),
    .sw_state_o    (sw_state_o),
    .evt_valid_o   (evt_valid_o),
    .evt_ready_i   (evt_ready_i),
    .evt_state_o   (evt_state_o),
    .evt_changed_o (evt_changed_o),
    .evt_overflow_o(evt_overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] st, input logic [7:0] chg, input logic ovf);
    evt_t e;
    e.st  = st;
    e.chg = chg;
    e.ovf = ovf;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every accepted handshake must match the oldest expected event.
  always @(negedge clk) begin
    if (rst_n && evt_valid_o && evt_ready_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {24'h0, evt_changed_o}, 32'h0);
      end else begin
        evt_t e;
        e = exp_q.pop_front();
        check("sb_state",    {24'h0, evt_state_o},   {24'h0, e.st});
        check("sb_changed",  {24'h0, evt_changed_o}, {24'h0, e.chg});
        check("sb_overflow", {31'h0, evt_overflow_o}, {31'h0, e.ovf});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       seen;
    logic [7:0] prev;

    vecs[0] = '{8'hFE, 8'h01, 8'h01};
    vecs[1] = '{8'hF0, 8'h0F, 8'h0E};
    vecs[2] = '{8'h0F, 8'hF0, 8'hFF};
    vecs[3] = '{8'hFF, 8'h00, 8'hF0};
    vecs[4] = '{8'h7F, 8'h80, 8'h80};
    vecs[5] = '{8'hFF, 8'h00, 8'h80};

    rst_n       = 1'b0;
    sw_n_i      = 8'hFF;
    evt_ready_i = 1'b0;
    repeat (3) tick();
    check("rst_sw_state", {24'h0, sw_state_o},    32'h0);
    check("rst_valid",    {31'h0, evt_valid_o},   32'h0);
    check("rst_evt_state", {24'h0, evt_state_o},  32'h0);
    check("rst_changed",  {24'h0, evt_changed_o}, 32'h0);
    check("rst_overflow", {31'h0, evt_overflow_o}, 32'h0);
    rst_n = 1'b1;

    // Idle with all switches released: no event may appear.
    evt_ready_i = 1'b1;
    seen = 1'b0;
    repeat (50) begin
      tick();
      seen |= evt_valid_o;
    end
    check("idle_no_valid", {31'h0, seen}, 32'h0);
    check("idle_sw_state", {24'h0, sw_state_o}, 32'h0);
    evt_ready_i = 1'b0;

    // Table: each new level lands exactly at E0+5 and is handshaken once.
    prev = 8'h00;
    for (int i = 0; i < 6; i++) begin
      push(vecs[i].exp_state, vecs[i].exp_changed, 1'b0);
      sw_n_i = vecs[i].sw_n;
      repeat (5) tick();
      check("vec_pre_valid", {31'h0, evt_valid_o}, 32'h0);
      check("vec_pre_state", {24'h0, sw_state_o}, {24'h0, prev});
      tick();
      check("vec_sw_state", {24'h0, sw_state_o}, {24'h0, vecs[i].exp_state});
      check("vec_valid",    {31'h0, evt_valid_o}, 32'h1);
      evt_ready_i = 1'b1;
      tick();
      evt_ready_i = 1'b0;
      check("vec_post_valid", {31'h0, evt_valid_o}, 32'h0);
      prev = vecs[i].exp_state;
    end

    // Bit3 low for one cycle less than the debounce: must be ignored.
    seen = 1'b0;
    sw_n_i = 8'hF7;
    repeat (3) begin
      tick();
      seen |= evt_valid_o | (|sw_state_o);
    end
    sw_n_i = 8'hFF;
    repeat (10) begin
      tick();
      seen |= evt_valid_o | (|sw_state_o);
    end
    check("glitch_ignored", {31'h0, seen}, 32'h0);

    // Bit3 low for exactly the debounce length: press and release both reported.
    evt_ready_i = 1'b1;
    push(8'h08, 8'h08, 1'b0);
    push(8'h00, 8'h08, 1'b0);
    sw_n_i = 8'hF7;
    repeat (4) tick();
    sw_n_i = 8'hFF;
    repeat (12) tick();
    evt_ready_i = 1'b0;
    check("pulse4_events", exp_q.size(), 32'h0);

    // Second change while pending merges and flags overflow.
    sw_n_i = 8'hFE;
    repeat (6) tick();
    check("merge_first_valid", {31'h0, evt_valid_o}, 32'h1);
    sw_n_i = 8'hFC;
    repeat (6) tick();
    check("merge_state",    {24'h0, evt_state_o},   32'h03);
    check("merge_changed",  {24'h0, evt_changed_o}, 32'h03);
    check("merge_overflow", {31'h0, evt_overflow_o}, 32'h1);
    push(8'h03, 8'h03, 1'b1);
    evt_ready_i = 1'b1;
    tick();
    evt_ready_i = 1'b0;
    check("merge_post_valid", {31'h0, evt_valid_o}, 32'h0);
    push(8'h00, 8'h03, 1'b0);
    sw_n_i = 8'hFF;
    repeat (6) tick();
    check("reload_overflow", {31'h0, evt_overflow_o}, 32'h0);
    evt_ready_i = 1'b1;
    tick();
    evt_ready_i = 1'b0;

    // Bit2 settles on the very edge that accepts the pending bit0 event.
    sw_n_i = 8'hFE;
    repeat (6) tick();
    push(8'h01, 8'h01, 1'b0);
    sw_n_i = 8'hFA;
    repeat (5) tick();
    evt_ready_i = 1'b1;
    tick();
    evt_ready_i = 1'b0;
    check("same_edge_valid",    {31'h0, evt_valid_o},   32'h1);
    check("same_edge_state",    {24'h0, evt_state_o},   32'h05);
    check("same_edge_changed",  {24'h0, evt_changed_o}, 32'h04);
    check("same_edge_overflow", {31'h0, evt_overflow_o}, 32'h0);
    push(8'h05, 8'h04, 1'b0);
    evt_ready_i = 1'b1;
    tick();
    push(8'h00, 8'h05, 1'b0);
    sw_n_i = 8'hFF;
    repeat (8) tick();
    evt_ready_i = 1'b0;

    // Reset with an event pending and another bit mid-debounce.
    sw_n_i = 8'hFD;
    repeat (6) tick();
    check("pre_reset_valid", {31'h0, evt_valid_o}, 32'h1);
    sw_n_i = 8'hF9;
    repeat (4) tick();
    #1 rst_n = 1'b0;
    #1;
    check("async_sw_state", {24'h0, sw_state_o},    32'h0);
    check("async_valid",    {31'h0, evt_valid_o},   32'h0);
    check("async_state",    {24'h0, evt_state_o},   32'h0);
    check("async_changed",  {24'h0, evt_changed_o}, 32'h0);
    check("async_overflow", {31'h0, evt_overflow_o}, 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("post_rst_pre_valid", {31'h0, evt_valid_o}, 32'h0);
    tick();
    check("post_rst_valid",    {31'h0, evt_valid_o}, 32'h1);
    check("post_rst_sw_state", {24'h0, sw_state_o},  32'h06);
    push(8'h06, 8'h06, 1'b0);
    evt_ready_i = 1'b1;
    tick();
    push(8'h00, 8'h06, 1'b0);
    sw_n_i = 8'hFF;
    repeat (8) tick();
    evt_ready_i = 1'b0;
    check("queue_drained", exp_q.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
